// File: rtl/jt51_lfo_mod.sv
// jt51_lfo_mod: applies frame-sampled LFO PM/AM per slot, producing extended key code and AM attenuation.
module jt51_lfo_mod #(
  parameter int KFW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           zero,
  input  logic [6:0]     am,
  input  logic [7:0]     pm_u,
  input  logic [6:0]     kc,
  input  logic [KFW-1:0] kf,
  input  logic [2:0]     pms,
  input  logic [1:0]     ams,
  output logic [6:0]     kcex,
  output logic [KFW-1:0] kfex,
  output logic [8:0]     am_att,
  output logic [4:0]     slot
);
  logic [4:0]  cnt, cur, slot1;
  logic [6:0]  am_h, am_e;
  logic [7:0]  pm_h, pm_e, off_c, off1;
  logic [3:0]  semi, semi2, code;
  logic [12:0] lin_c, lin1, sc;
  logic [13:0] s;
  logic [8:0]  am_c, am1;
  logic [6:0]  u;
  logic [2:0]  oct;
  logic        neg1;
  assign cur  = zero ? 5'd0 : cnt + 5'd1;
  assign am_e = zero ? am : am_h;
  assign pm_e = zero ? pm_u : pm_h;
  // invalid note codes (low bits 3) fold onto the previous valid code
  assign semi  = 4'({2'b0, kc[3:2]} * 4'd3) + {2'b0, (kc[1:0] == 2'd3) ? 2'd2 : kc[1:0]};
  assign lin_c = 13'(kc[6:4]) * 13'd768 + {3'b0, semi, kf};
  assign off_c = pms == 3'd0 ? 8'd0 : pms == 3'd7 ? {pm_e[6:0], 1'b0} : {1'b0, pm_e[6:0] >> (3'd6 - pms)};
  assign am_c  = ams == 2'd0 ? 9'd0 : 9'(am_e) << (ams - 2'd1);
  assign s     = {1'b0, lin1} + (neg1 ? -{6'b0, off1} : {6'b0, off1});
  assign sc    = s[13] ? 13'd0 : s > 14'd6143 ? 13'd6143 : s[12:0];
  assign u     = sc[12:6];
  assign oct   = 3'(u / 7'd12);
  assign semi2 = 4'(u % 7'd12);
  assign code  = semi2 + semi2 / 4'd3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      am_h   <= '0;
      pm_h   <= '0;
      lin1   <= '0;
      off1   <= '0;
      neg1   <= 1'b0;
      am1    <= '0;
      slot1  <= '0;
      kcex   <= '0;
      kfex   <= '0;
      am_att <= '0;
      slot   <= '0;
    end else if (cen) begin
      cnt    <= cur;
      am_h   <= am_e;
      pm_h   <= pm_e;
      lin1   <= lin_c;
      off1   <= off_c;
      neg1   <= pm_e[7];
      am1    <= am_c;
      slot1  <= cur;
      kcex   <= {oct, code};
      kfex   <= sc[KFW-1:0];
      am_att <= am1;
      slot   <= slot1;
    end
  end
endmodule

// File: tb/tb_jt51_lfo_mod.sv
// tb_jt51_lfo_mod: directed scoreboard bench for jt51_lfo_mod.
module tb_jt51_lfo_mod;
  logic       clk = 1'b0, rst, cen, zero;
  logic [6:0] am, kc, kcex;
  logic [7:0] pm_u;
  logic [5:0] kf, kfex;
  logic [2:0] pms;
  logic [1:0] ams;
  logic [8:0] am_att;
  logic [4:0] slot;
  typedef struct packed {
    logic [6:0] kc;
    logic [5:0] kf;
    logic [8:0] am;
    logic [4:0] slot;
  } exp_t;
  exp_t q[$];
  exp_t last;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_amh = 0, m_pmh = 0;
  jt51_lfo_mod dut (.clk(clk), .rst(rst), .cen(cen), .zero(zero), .am(am), .pm_u(pm_u),
    .kc(kc), .kf(kf), .pms(pms), .ams(ams), .kcex(kcex), .kfex(kfex), .am_att(am_att), .slot(slot));
  always #5 clk = ~clk;
  function automatic int semi_tab(input int n);
    case (n)
      0: return 0;  1: return 1;  2: return 2;  3: return 2;
      4: return 3;  5: return 4;  6: return 5;  7: return 5;
      8: return 6;  9: return 7;  10: return 8; 11: return 8;
      12: return 9; 13: return 10; default: return 11;
    endcase
  endfunction
  function automatic exp_t model(input int k, input int f, input int ps, input int as, input int sl, input int av, input int pv);
    int lin, m, off, s, o, se;
    exp_t e;
    lin = (k / 16) * 768 + semi_tab(k % 16) * 64 + f;
    m = pv % 128;
    off = ps == 0 ? 0 : ps == 6 ? m : ps == 7 ? m * 2 : m / (1 << (6 - ps));
    s = pv >= 128 ? lin - off : lin + off;
    if (s < 0) s = 0;
    if (s > 6143) s = 6143;
    o = 0;
    while (s >= 768) begin
      s -= 768;
      o++;
    end
    se = s / 64;
    e.kc = 7'(o * 16 + se + se / 3);
    e.kf = 6'(s % 64);
    e.am = 9'(as == 0 ? 0 : av * (1 << (as - 1)));
    e.slot = 5'(sl);
    return e;
  endfunction
  task automatic check(input string tag, input exp_t e);
    exp_t o;
    o = '{kcex, kfex, am_att, slot};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed kcex=%h kfex=%0d am_att=%0d slot=%0d, expected kcex=%h kfex=%0d am_att=%0d slot=%0d",
             tag, o.kc, o.kf, o.am, o.slot, e.kc, e.kf, e.am, e.slot);
    end
  endtask
  task automatic step(input string tag, input logic z, input logic [6:0] a, input logic [7:0] p,
                      input logic [6:0] k, input logic [5:0] f, input logic [2:0] ps, input logic [1:0] as);
    int cur;
    cen = 1'b1; zero = z; am = a; pm_u = p; kc = k; kf = f; pms = ps; ams = as;
    cur = z ? 0 : (m_cnt + 1) % 32;
    m_cnt = cur;
    if (z) begin
      m_amh = a;
      m_pmh = p;
    end
    q.push_back(model(k, f, ps, as, cur, m_amh, m_pmh));
    @(posedge clk);
    #1;
    if (q.size() == 2) begin
      last = q.pop_front();
      check(tag, last);
    end
  endtask
  initial begin
    rst = 1'b1; cen = 1'b0; zero = 1'b0; am = '0; pm_u = '0; kc = '0; kf = '0; pms = '0; ams = '0;
    #22;
    check("reset", '0);
    rst = 1'b0;
    step("pm_pos", 1, 0, 8'h05, 7'h4A, 0, 7, 0);
    step("pm_pos2", 0, 0, 8'h05, 7'h4A, 0, 7, 0);
    step("pm_neg", 1, 0, 8'h85, 7'h40, 0, 7, 0);
    step("clamp_hi", 1, 0, 8'h7F, 7'h7E, 63, 7, 0);
    step("clamp_lo", 1, 0, 8'hFF, 7'h00, 0, 7, 0);
    step("bad_note", 0, 0, 8'hFF, 7'h43, 5, 0, 0);
    step("bad_note2", 0, 0, 8'hFF, 7'h2F, 0, 0, 0);
    step("neg_zero", 1, 0, 8'h80, 7'h40, 0, 7, 0);
    step("pms_mid", 1, 0, 8'h7F, 7'h35, 20, 3, 0);
    step("pms6", 0, 0, 8'h00, 7'h35, 20, 6, 0);
    step("am3", 1, 7'h7F, 8'h00, 7'h10, 0, 0, 3);
    step("am0", 0, 7'h7F, 8'h00, 7'h10, 0, 0, 0);
    for (int i = 2; i < 10; i++) step("am_hold", 0, 7'h10, 8'h00, 7'h10, 0, 0, 3);
    step("am_new", 1, 7'h10, 8'h00, 7'h10, 0, 0, 3);
    step("am1", 0, 7'h55, 8'h00, 7'h10, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cen = 1'b0; zero = 1'b1; am = 7'h3; kc = 7'h77;
      @(posedge clk);
      #1;
      check("cen_hold", last);
    end
    for (int i = 0; i < 34; i++) step("wrap", 0, 7'h2, 8'h00, 7'(i), 6'(i), 3'(i), 2'(i));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", '0);
    #3;
    rst = 1'b0;
    q.delete();
    m_cnt = 0; m_amh = 0; m_pmh = 0;
    step("post_rst", 0, 7'h9, 8'h85, 7'h4A, 3, 7, 2);
    step("post_rst2", 0, 7'h9, 8'h85, 7'h4A, 3, 7, 2);
    step("realign", 1, 7'h9, 8'h85, 7'h4A, 3, 7, 2);
    step("realign2", 0, 7'h1, 8'h01, 7'h4A, 3, 7, 2);
    step("flush", 0, 7'h1, 8'h01, 7'h00, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
